// File: rtl/dds.sv
// dds: free-running phase accumulator feeding a sine lookup, registered 8-bit offset-binary sample.
// Build option DDS_FULL_LUT_EN selects a 256-entry full-cycle table instead of quarter-wave folding.
module dds #(
  parameter int unsigned PHASE_W = 16,
  parameter logic [31:0] FTW     = 32'd1024
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] Magnitude
);

  logic [PHASE_W-1:0] phase;
  logic [7:0]         index;
  logic [7:0]         sample;

  // Top 8 phase bits address the table; lower bits are simply truncated.
  assign index = phase[PHASE_W-1 -: 8];

  // round(127 * sin(2*pi*k/256)) for k = 0..64
  function automatic logic [6:0] quarter(input logic [6:0] k);
    logic [6:0] q;
    case (k)
      7'd0:  q = 7'd0;   7'd1:  q = 7'd3;   7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
      7'd4:  q = 7'd12;  7'd5:  q = 7'd16;  7'd6:  q = 7'd19;  7'd7:  q = 7'd22;
      7'd8:  q = 7'd25;  7'd9:  q = 7'd28;  7'd10: q = 7'd31;  7'd11: q = 7'd34;
      7'd12: q = 7'd37;  7'd13: q = 7'd40;  7'd14: q = 7'd43;  7'd15: q = 7'd46;
      7'd16: q = 7'd49;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
      7'd20: q = 7'd60;  7'd21: q = 7'd63;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
      7'd24: q = 7'd71;  7'd25: q = 7'd73;  7'd26: q = 7'd76;  7'd27: q = 7'd78;
      7'd28: q = 7'd81;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd88;
      7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
      7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
      7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd111;
      7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
      7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
      7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
      7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
      7'd60: q = 7'd126; 7'd61: q = 7'd127; 7'd62: q = 7'd127; 7'd63: q = 7'd127;
      7'd64: q = 7'd127;
      default: q = 7'd0;
    endcase
    return q;
  endfunction

  // Second and fourth quadrants mirror the table; the upper half is negated around midscale.
  function automatic logic [7:0] fold(input logic [7:0] i);
    logic [6:0] k;
    logic [6:0] q;
    k = i[6] ? (7'd64 - {1'b0, i[5:0]}) : {1'b0, i[5:0]};
    q = quarter(k);
    return i[7] ? (8'd128 - {1'b0, q}) : (8'd128 + {1'b0, q});
  endfunction

`ifdef DDS_FULL_LUT_EN
  logic [7:0] full_lut [256];

  for (genvar g = 0; g < 256; g++) begin : g_lut
    assign full_lut[g] = fold(8'(g));
  end

  assign sample = full_lut[index];
`else
  assign sample = fold(index);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= '0;
      Magnitude <= 8'd128;
    end else begin
      phase     <= phase + FTW[PHASE_W-1:0];
      Magnitude <= sample;
    end
  end

endmodule

// File: tb/tb_dds.sv
// tb_dds: five dds instances with different tuning words checked against a sine reference model.
`timescale 1ns/1ps
module tb_dds;

  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] mag [NI];

  longint ftws [NI] = '{1024, 256, 0, 65535, 32768};

  int total = 0;
  int bad   = 0;
  int n     = 0;

  logic [7:0] exp_q [$];

  typedef struct {
    int sel;
    int edge_n;
    int exp;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  dds #(.PHASE_W(16), .FTW(32'd1024))  u_def  (.clk(clk), .rst(rst), .Magnitude(mag[0]));
  dds #(.PHASE_W(16), .FTW(32'd256))   u_256  (.clk(clk), .rst(rst), .Magnitude(mag[1]));
  dds #(.PHASE_W(16), .FTW(32'd0))     u_zero (.clk(clk), .rst(rst), .Magnitude(mag[2]));
  dds #(.PHASE_W(16), .FTW(32'd65535)) u_neg  (.clk(clk), .rst(rst), .Magnitude(mag[3]));
  dds #(.PHASE_W(16), .FTW(32'd32768)) u_half (.clk(clk), .rst(rst), .Magnitude(mag[4]));

  // Sine sample straight from the math: 128 + round-half-away(127*sin(2*pi*i/256)).
  function automatic int s_ref(int i);
    real v;
    int  q;
    v = 127.0 * $sin(2.0 * 3.14159265358979323846 * real'(i) / 256.0);
    if (v >= 0.0) q = int'($floor(v + 0.5));
    else          q = -int'($floor(-v + 0.5));
    return 128 + q;
  endfunction

  function automatic int expect_at(longint ftw, int edge_n);
    longint ph;
    ph = ((longint'(edge_n) - 1) * ftw) % 65536;
    return s_ref(int'(ph >> 8));
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_all_const(string name, int exp);
    for (int s = 0; s < NI; s++)
      check($sformatf("%s[%0d]", name, s), int'(mag[s]), exp);
  endtask

  task automatic check_model(string name);
    for (int s = 0; s < NI; s++)
      check($sformatf("%s[%0d] edge %0d", name, s, n), int'(mag[s]), expect_at(ftws[s], n));
  endtask

  task automatic step();
    @(negedge clk);
    n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
  endtask

  initial begin
    int ones;
    int tops;
    int len;
    int off;

    // Reset is asynchronous: output is midscale before any clock edge.
    #1 rst = 1'b1;
    #1 check_all_const("reset_async_start", 128);
    repeat (3) begin
      @(negedge clk);
      check_all_const("reset_hold", 128);
    end
    rst = 1'b0;
    n = 0;

    // Spec key points, one fresh reset per vector.
    vecs[0]  = '{0, 1, 128};   vecs[1]  = '{0, 2, 140};   vecs[2]  = '{0, 17, 255};
    vecs[3]  = '{0, 33, 128};  vecs[4]  = '{0, 49, 1};    vecs[5]  = '{0, 65, 128};
    vecs[6]  = '{1, 65, 255};  vecs[7]  = '{1, 193, 1};   vecs[8]  = '{2, 7, 128};
    vecs[9]  = '{3, 2, 125};   vecs[10] = '{4, 1, 128};   vecs[11] = '{4, 2, 128};
    vecs[12] = '{4, 3, 128};
    foreach (vecs[v]) begin
      do_reset();
      while (n < vecs[v].edge_n) step();
      check($sformatf("vec%0d sel%0d edge%0d", v, vecs[v].sel, vecs[v].edge_n),
            int'(mag[vecs[v].sel]), vecs[v].exp);
    end

    // Long run on the default instance through the expected queue, plus period statistics.
    do_reset();
    ones = 0;
    tops = 0;
    for (int e = 1; e <= 1000; e++) begin
      exp_q.push_back(8'(expect_at(1024, n + 1)));
      step();
      check($sformatf("long edge %0d", n), int'(mag[0]), int'(exp_q.pop_front()));
      check($sformatf("long range edge %0d", n), int'(mag[0] >= 8'd1 && mag[0] <= 8'd255), 1);
      if (mag[0] == 8'd1)   ones++;
      if (mag[0] == 8'd255) tops++;
      if (e % 64 == 0) begin
        check($sformatf("period min count win %0d", e / 64), ones, 1);
        check($sformatf("period max count win %0d", e / 64), tops, 1);
        ones = 0;
        tops = 0;
      end
      if (e <= 300) check_model("long_all");
    end

    // Mid-operation reset at edge 20, sequence must restart from edge 1.
    do_reset();
    repeat (19) begin
      step();
      check_model("pre_mid");
    end
    rst = 1'b1;
    #1 check_all_const("mid_async", 128);
    @(negedge clk);
    check_all_const("mid_hold", 128);
    rst = 1'b0;
    n = 0;
    step();
    check("mid_restart edge1", int'(mag[0]), 128);
    step();
    check("mid_restart edge2", int'(mag[0]), 140);
    repeat (20) begin
      step();
      check_model("mid_post");
    end

    // Random run lengths interrupted by resets landing at random points within a cycle.
    for (int it = 0; it < 15; it++) begin
      len = $urandom_range(1, 150);
      repeat (len) begin
        step();
        check_model($sformatf("rand%0d", it));
      end
      @(posedge clk);
      off = $urandom_range(1, 8);
      #(off) rst = 1'b1;
      #1 check_all_const($sformatf("rand%0d_async", it), 128);
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check_all_const($sformatf("rand%0d_hold", it), 128);
      rst = 1'b0;
      n = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds.md
# dds

Direct digital synthesizer: a free-running phase accumulator drives a quarter-wave sine lookup to produce an 8-bit unsigned sine sample every clock. It is the carrier source for the digital modulation datapath. Its frequency is fixed at elaboration by a tuning-word parameter.

## Interface
- PHASE_W, 16: phase accumulator width in bits; legal range 10 to 32.
- FTW, 1024: frequency tuning word, PHASE_W bits wide, added to the phase every clock; f_out = f_clk * FTW / 2^PHASE_W.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- Magnitude  output  8  sine sample, unsigned offset binary; midscale 128 represents zero.

## Operation
- Phase register `phase` is PHASE_W bits. Each clock, `phase <= phase + FTW`, modulo 2^PHASE_W, with silent wrap and no carry out.
- LUT index `i = phase[PHASE_W-1 : PHASE_W-8]`, which is 8 bits giving 256 points per cycle. The lower phase bits are truncated, with no rounding or dither.
- Quarter-wave table: `q[k] = round(127 * sin(2*pi*k/256))` for k = 0..64, giving 65 entries. q[0] = 0, q[4] = 12, q[64] = 127. Round half away from zero.
- Quadrant mapping from i to the sample value S(i):
  - i = 0..63: 128 + q[i]
  - i = 64..127: 128 + q[128 - i]
  - i = 128..191: 128 - q[i - 128]
  - i = 192..255: 128 - q[256 - i]
- Range of S is 1..255. The value 0 is never produced.
- Key points: S(0) = 128, S(64) = 255, S(128) = 128, S(192) = 1.
- Magnitude is registered. Each clock, `Magnitude <= S(i)`, where i is taken from the phase value before that edge's increment.

## Timing
- While rst is high: phase = 0 and Magnitude = 128, asynchronously and immediately.
- Before the first reset, state is undefined. The design has no power-on initialisation.
- Latency from phase to output is one clock.
- At the n-th rising edge after rst falls (n ≥ 1): Magnitude = S(((n-1) * FTW mod 2^PHASE_W) >> (PHASE_W-8)).
- The first edge after reset therefore produces 128.
- Reset asserted mid-cycle: the output snaps to 128 and the phase to 0 without waiting for a clock edge. The sequence restarts from edge 1 after release.
- Edge case FTW = 0: the output stays at 128 forever.
- Edge case FTW = 2^(PHASE_W-1): the output alternates 128, 128. Indices 0 and 128 both give 128.
- No handshake. A new sample is valid every clock.

## Configuration
- Macro: DDS_FULL_LUT_EN.
  - Defined: a 256-entry full-cycle table holding S(i) directly replaces the quarter-wave table and quadrant logic.
  - Undefined (default): the 65-entry quarter-wave table with quadrant folding is used.
- Magnitude must be bit-identical, cycle for cycle, in both builds. The macro trades area for logic depth only.

## Test plan
- Reset value: hold rst = 1 for 3 clocks -> Magnitude = 128 throughout. Also assert rst asynchronously between edges -> Magnitude = 128 before the next edge.
- Default waveform (PHASE_W = 16, FTW = 1024), release reset:
  - edges 1, 2, 17, 33, 49 -> 128, 140, 255, 128, 1
  - edge 65 -> 128; period is 64 clocks
- Long run: 1000 clocks with defaults -> every sample equals the golden S() model and lies in 1..255. Exactly one 255 and one 1 per 64-clock period.
- Mid-operation reset: pulse rst for 1 clock at edge 20 -> Magnitude = 128 during reset. The post-release sequence repeats 128, 140, … exactly.
- Tuning sweep: FTW = 256 -> 256-clock period with S(64) = 255 at edge 65. FTW = 0 -> constant 128. FTW = 65535 -> index decreasing, with edge 2 giving S(255) = 125.
- Configuration equivalence: run the default sequence for 512 clocks with and without DDS_FULL_LUT_EN defined -> identical Magnitude traces.
